// File: rtl/ddr_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_rd_arbiter
// Round-robin read arbiter that shares one AXI read channel (PS7 S_AXI_HP0)
// among NUM_REQ PL requesters. One burst is in flight at a time, so the R
// channel is routed straight to the current owner with no ID handling.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester command handshake (ready is a
//                          one-hot pulse in IDLE)
//   req_addr, req_len      packed per-requester start address / beats-1
//   rsp_valid/rsp_ready    per-requester response stream handshake
//   rsp_data/last/err      shared response payload, combinational from R
//   m_axi_ar*              AXI read address channel
//   m_axi_r*               AXI read data channel
//   busy                   high while a burst is owned (ADDR or DATA)
//   grant_id               index of the current owner
//   proto_err              sticky RLAST / beat-count mismatch flag
// ---------------------------------------------------------------------------
// state   | meaning
// --------+------------------------------------------------------------------
// ST_IDLE | no owner; arbitrate among req_valid
// ST_ADDR | m_axi_arvalid high, waiting for m_axi_arready
// ST_DATA | forwarding R beats to the owner until the rlast handshake
// ---------------------------------------------------------------------------
module ddr_rd_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int LEN_W   = 8,
   localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  req_len,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_last,
   output logic                      rsp_err,
   output logic [ADDR_W-1:0]         m_axi_araddr,
   output logic [LEN_W-1:0]          m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_W-1:0]         m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic                      busy,
   output logic [GID_W-1:0]          grant_id,
   output logic                      proto_err
);

   localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W / 8));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [GID_W-1:0]  rr_ptr_q;
   logic [GID_W-1:0]  grant_id_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [LEN_W-1:0]  arlen_q;
   logic [LEN_W-1:0]  beat_cnt_q;
   logic              proto_err_q;

   logic              win_found;
   logic [GID_W-1:0]  win_idx;
   logic              accept;
   logic              r_hs;

   // Search upward from rr_ptr with wrap; first requesting index wins.
   always_comb begin
      logic [GID_W:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (GID_W+1)'(k);
         if (cand >= (GID_W+1)'(NUM_REQ))
            cand = cand - (GID_W+1)'(NUM_REQ);
         if (!win_found && req_valid[cand[GID_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[GID_W-1:0];
         end
      end
   end

   assign accept = (state_q == ST_IDLE) && win_found;
   assign r_hs   = (state_q == ST_DATA) && m_axi_rvalid && m_axi_rready;

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)                    state_d = ST_ADDR;
         ST_ADDR: if (m_axi_arready)             state_d = ST_DATA;
         ST_DATA: if (r_hs && m_axi_rlast)       state_d = ST_IDLE;
         default:                                state_d = ST_IDLE;
      endcase
   end

   // Datapath registers: captured command, pointer, beat counter, error flag
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         beat_cnt_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (accept) begin
            grant_id_q <= win_idx;
            araddr_q   <= req_addr[win_idx*ADDR_W +: ADDR_W];
            arlen_q    <= req_len[win_idx*LEN_W +: LEN_W];
         end
         if (state_q == ST_ADDR && m_axi_arready)
            beat_cnt_q <= '0;
         if (r_hs) begin
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            // Early rlast or missing rlast on the final beat; burst still
            // terminates on rlast either way.
            if ((m_axi_rlast && beat_cnt_q != arlen_q) ||
                (!m_axi_rlast && beat_cnt_q == arlen_q))
               proto_err_q <= 1'b1;
            if (m_axi_rlast)
               rr_ptr_q <= (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0
                                                                : grant_id_q + GID_W'(1);
         end
      end
   end

   // Output logic
   always_comb begin
      req_ready    = '0;
      rsp_valid    = '0;
      m_axi_rready = 1'b0;
      // Gated by aresetn so the pulse is low while reset is held.
      if (accept && aresetn)
         req_ready[win_idx] = 1'b1;
      if (state_q == ST_DATA) begin
         rsp_valid[grant_id_q] = m_axi_rvalid;
         m_axi_rready          = rsp_ready[grant_id_q];
      end
   end

   assign rsp_data      = m_axi_rdata;
   assign rsp_last      = (state_q == ST_DATA) && m_axi_rlast;
   assign rsp_err       = (state_q == ST_DATA) && (m_axi_rresp != 2'b00);

   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = AR_SIZE;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arvalid = (state_q == ST_ADDR);

   assign busy          = (state_q != ST_IDLE);
   assign grant_id      = grant_id_q;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
module tb_ddr_rd_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 64;
   localparam int LEN_W   = 8;
   localparam int GID_W   = 2;

   logic                      aclk;
   logic                      aresetn;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*LEN_W-1:0]  req_len;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_last;
   logic                      rsp_err;
   logic [ADDR_W-1:0]         m_axi_araddr;
   logic [LEN_W-1:0]          m_axi_arlen;
   logic [2:0]                m_axi_arsize;
   logic [1:0]                m_axi_arburst;
   logic                      m_axi_arvalid;
   logic                      m_axi_arready;
   logic [DATA_W-1:0]         m_axi_rdata;
   logic [1:0]                m_axi_rresp;
   logic                      m_axi_rlast;
   logic                      m_axi_rvalid;
   logic                      m_axi_rready;
   logic                      busy;
   logic [GID_W-1:0]          grant_id;
   logic                      proto_err;

   int n_checks = 0;
   int n_errors = 0;

   ddr_rd_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready),
      .busy(busy), .grant_id(grant_id), .proto_err(proto_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int exp_rr [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
   int nbeat;
   int cyc;
   logic rdy_now;

   initial begin
      aresetn       = 1'b0;
      req_valid     = '0;
      req_addr      = '0;
      req_len       = '0;
      rsp_ready     = '0;
      m_axi_arready = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      m_axi_rvalid  = 1'b0;

      repeat (3) tick();
      chk("rst_busy",      64'(busy),          64'd0);
      chk("rst_arvalid",   64'(m_axi_arvalid), 64'd0);
      chk("rst_grant",     64'(grant_id),      64'd0);
      chk("rst_proto_err", 64'(proto_err),     64'd0);
      chk("rst_req_ready", 64'(req_ready),     64'd0);
      chk("rst_araddr",    64'(m_axi_araddr),  64'd0);
      aresetn = 1'b1;
      tick();

      // ---- single request: req0, addr 0x0010_0000, len 3 ----
      req_addr[0*ADDR_W +: ADDR_W] = 32'h0010_0000;
      req_len[0*LEN_W +: LEN_W]    = 8'd3;
      req_valid     = 4'b0001;
      m_axi_arready = 1'b1;
      #1;
      chk("single_req_ready", 64'(req_ready), 64'h1);
      chk("single_busy_idle", 64'(busy),      64'd0);
      tick();
      req_valid = '0;
      chk("single_arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("single_araddr",  64'(m_axi_araddr),  64'h0010_0000);
      chk("single_arlen",   64'(m_axi_arlen),   64'd3);
      chk("single_arsize",  64'(m_axi_arsize),  64'd3);
      chk("single_arburst", 64'(m_axi_arburst), 64'd1);
      chk("single_busy",    64'(busy),          64'd1);
      chk("single_req_rdy_busy", 64'(req_ready), 64'd0);
      tick();
      chk("single_arvalid_drop", 64'(m_axi_arvalid), 64'd0);
      for (int b = 0; b < 4; b++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = 64'hA000 + 64'(b);
         m_axi_rlast  = (b == 3);
         rsp_ready    = 4'b0001;
         #1;
         chk("single_rsp_valid", 64'(rsp_valid),    64'h1);
         chk("single_rready",    64'(m_axi_rready), 64'd1);
         chk("single_rsp_data",  64'(rsp_data),     64'hA000 + 64'(b));
         chk("single_rsp_last",  64'(rsp_last),     64'(b == 3));
         tick();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      rsp_ready    = '0;
      chk("single_busy_after", 64'(busy),      64'd0);
      chk("single_proto_ok",   64'(proto_err), 64'd0);

      // ---- round-robin: all requesters, len 0; pointer starts at 1 ----
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = 32'(i) * 32'h1000;
         req_len[i*LEN_W +: LEN_W]    = 8'd0;
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_req_ready", 64'(req_ready), 64'(1) << exp_rr[k]);
         tick();
         chk("rr_grant",  64'(grant_id),     64'(exp_rr[k]));
         chk("rr_araddr", 64'(m_axi_araddr), 64'(exp_rr[k]) * 64'h1000);
         tick();
         m_axi_rvalid = 1'b1;
         m_axi_rlast  = 1'b1;
         m_axi_rdata  = 64'(k);
         rsp_ready    = 4'b1111;
         #1;
         chk("rr_rsp_valid", 64'(rsp_valid), 64'(1) << exp_rr[k]);
         tick();
         m_axi_rvalid = 1'b0;
         m_axi_rlast  = 1'b0;
      end
      req_valid = '0;
      rsp_ready = '0;

      // ---- backpressure: req1, arready low 5 cycles, toggling rsp_ready ----
      req_addr[1*ADDR_W +: ADDR_W] = 32'h2000_0040;
      req_len[1*LEN_W +: LEN_W]    = 8'd7;
      req_valid     = 4'b0010;
      m_axi_arready = 1'b0;
      #1;
      chk("bp_req_ready", 64'(req_ready), 64'h2);
      tick();
      req_valid = '0;
      for (int c = 0; c < 6; c++) begin
         m_axi_arready = (c == 5);
         #1;
         chk("bp_arvalid", 64'(m_axi_arvalid), 64'd1);
         chk("bp_araddr",  64'(m_axi_araddr),  64'h2000_0040);
         chk("bp_arlen",   64'(m_axi_arlen),   64'd7);
         tick();
      end
      m_axi_arready = 1'b1;
      nbeat = 0;
      cyc   = 0;
      while (nbeat < 8 && cyc < 40) begin
         rdy_now      = (cyc % 2 == 0);
         rsp_ready    = rdy_now ? 4'b0010 : 4'b0000;
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = 64'(nbeat);
         m_axi_rlast  = (nbeat == 7);
         #1;
         chk("bp_rready",    64'(m_axi_rready), 64'(rdy_now));
         chk("bp_rsp_valid", 64'(rsp_valid),    64'h2);
         chk("bp_rsp_data",  64'(rsp_data),     64'(nbeat));
         if (rdy_now) nbeat++;
         cyc++;
         tick();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      rsp_ready    = '0;
      chk("bp_beat_count", 64'(nbeat),     64'd8);
      chk("bp_busy_after", 64'(busy),      64'd0);
      chk("bp_proto_ok",   64'(proto_err), 64'd0);

      // ---- SLVERR on beat 2 of 4: req2 (pointer now 2) ----
      req_addr[2*ADDR_W +: ADDR_W] = 32'h0000_3000;
      req_len[2*LEN_W +: LEN_W]    = 8'd3;
      req_valid = 4'b0100;
      #1;
      chk("err_req_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      tick();
      for (int b = 0; b < 4; b++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rlast  = (b == 3);
         m_axi_rresp  = (b == 1) ? 2'b10 : 2'b00;
         rsp_ready    = 4'b0100;
         #1;
         chk("err_rsp_err", 64'(rsp_err), 64'(b == 1));
         tick();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      chk("err_proto_ok", 64'(proto_err), 64'd0);
      chk("err_busy",     64'(busy),      64'd0);

      // ---- early rlast: req3 len 3, rlast on beat 2 ----
      req_len[3*LEN_W +: LEN_W] = 8'd3;
      req_valid = 4'b1000;
      #1;
      chk("early_req_ready", 64'(req_ready), 64'h8);
      tick();
      req_valid = '0;
      tick();
      for (int b = 0; b < 2; b++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rlast  = (b == 1);
         rsp_ready    = 4'b1000;
         #1;
         tick();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      chk("early_proto_err", 64'(proto_err), 64'd1);
      chk("early_busy",      64'(busy),      64'd0);

      // next grant proceeds (pointer wrapped to 0)
      req_len[0*LEN_W +: LEN_W] = 8'd0;
      req_valid = 4'b0001;
      #1;
      chk("after_req_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      chk("after_arvalid", 64'(m_axi_arvalid), 64'd1);
      tick();
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b1;
      rsp_ready    = 4'b0001;
      #1;
      chk("after_rsp_valid", 64'(rsp_valid), 64'h1);
      tick();
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      chk("after_proto_sticky", 64'(proto_err), 64'd1);
      chk("after_busy",         64'(busy),      64'd0);

      // ---- reset mid-burst: req1 len 3, reset during beat 2 ----
      req_len[1*LEN_W +: LEN_W] = 8'd3;
      req_valid = 4'b0010;
      #1;
      chk("mid_req_ready", 64'(req_ready), 64'h2);
      tick();
      req_valid = '0;
      tick();
      m_axi_rvalid = 1'b1;
      m_axi_rlast  = 1'b0;
      rsp_ready    = 4'b0010;
      tick();
      #1;
      chk("mid_rsp_valid_pre", 64'(rsp_valid), 64'h2);
      aresetn = 1'b0;
      #1;
      chk("mid_busy",      64'(busy),          64'd0);
      chk("mid_arvalid",   64'(m_axi_arvalid), 64'd0);
      chk("mid_rsp_valid", 64'(rsp_valid),     64'd0);
      chk("mid_rready",    64'(m_axi_rready),  64'd0);
      chk("mid_grant",     64'(grant_id),      64'd0);
      chk("mid_proto_err", 64'(proto_err),     64'd0);
      chk("mid_araddr",    64'(m_axi_araddr),  64'd0);
      chk("mid_arlen",     64'(m_axi_arlen),   64'd0);
      chk("mid_rsp_last",  64'(rsp_last),      64'd0);
      m_axi_rvalid = 1'b0;
      rsp_ready    = '0;
      tick();
      aresetn = 1'b1;
      tick();
      // pointer back at 0: with req0 and req3 pending, req0 must win
      req_valid = 4'b1001;
      #1;
      chk("post_rst_ptr", 64'(req_ready), 64'h1);
      req_valid = 4'b0100;
      #1;
      chk("post_rst_req2", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      chk("post_rst_grant",   64'(grant_id),      64'd2);
      chk("post_rst_arvalid", 64'(m_axi_arvalid), 64'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
